// File: rtl/fir_partial_accumulator.sv
// Reduces a stream of unsigned tap-pair partial sums into filter output
// samples: every NUM_PARTIALS accepted beats (or fewer if in_last closes the
// frame early) produce one accumulated sample on a valid/ready output.
// A frame_err pulse flags any beat where in_last disagrees with the beat count.
module fir_partial_accumulator #(
    parameter int IN_WIDTH     = 17,
    parameter int NUM_PARTIALS = 4,
    parameter int ACC_WIDTH    = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 frame_err
);

    localparam int CNT_W = (NUM_PARTIALS > 1) ? $clog2(NUM_PARTIALS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PARTIALS - 1);

    // Parameter sanity: the accumulator must hold the worst-case sum exactly.
    generate
        if (ACC_WIDTH < IN_WIDTH + $clog2(NUM_PARTIALS)) begin : g_acc_too_narrow
            $error("fir_partial_accumulator: ACC_WIDTH too small for IN_WIDTH and NUM_PARTIALS");
        end
        if (NUM_PARTIALS < 2 || NUM_PARTIALS > 256) begin : g_bad_partials
            $error("fir_partial_accumulator: NUM_PARTIALS must be in 2..256");
        end
    endgenerate

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 frame_err_q, frame_err_d;
    // Low while reset is held and until the first clock after release, so the
    // input side stays closed until the block is actually running.
    logic                 live_q;

    logic                 accept;
    logic                 take;
    logic                 last_beat;
    logic                 close_frame;
    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] sum;

    // Handshakes, running sum and next-state selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        frame_err_d = 1'b0;

        // In HOLD a beat may only enter when the held sample leaves this cycle.
        in_ready  = (state_q == ST_HOLD) ? out_ready : live_q;
        out_valid = (state_q == ST_HOLD);

        accept      = in_valid && in_ready;
        take        = out_valid && out_ready;
        last_beat   = (cnt_q == LAST_CNT);
        close_frame = last_beat || in_last;
        in_ext      = ACC_WIDTH'(in_data);
        // cnt is zero on the first beat of every frame (including one that
        // arrives while a sample is being taken), so the old sum is dropped.
        sum         = (cnt_q == '0) ? in_ext : (acc_q + in_ext);

        if (take) begin
            state_d = ST_ACCUM;
        end

        if (accept) begin
            acc_d = sum;
            if (close_frame) begin
                out_data_d  = sum;
                state_d     = ST_HOLD;
                cnt_d       = '0;
                frame_err_d = (in_last != last_beat);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State, accumulator and output registers; async reset discards any frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            frame_err_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            frame_err_q <= frame_err_d;
            live_q      <= 1'b1;
        end
    end

    assign out_data  = out_data_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_fir_partial_accumulator.sv
// Bench for fir_partial_accumulator: directed scenarios followed by random
// traffic, all checked against a frame-level model (queue of beats, summed
// when a frame closes).
module tb_fir_partial_accumulator;

    localparam int IW = 17;
    localparam int NP = 4;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          frame_err;

    always #5 clk = ~clk;

    fir_partial_accumulator #(
        .IN_WIDTH    (IW),
        .NUM_PARTIALS(NP),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .frame_err(frame_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: beats of the open frame, the held sample and flags.
    int unsigned frame_q[$];
    bit          m_hold;
    int unsigned m_out;
    bit          m_err;
    bit          m_alive;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned frame_sum();
        int unsigned s = 0;
        foreach (frame_q[i]) s += frame_q[i];
        return s;
    endfunction

    // One clock cycle of traffic: drive, check in_ready, advance model, check outputs.
    task automatic step(input bit v, input int unsigned d, input bit l, input bit ordy);
        bit exp_rdy;
        bit acc;
        bit take;
        @(negedge clk);
        in_valid  = v;
        in_data   = d[IW-1:0];
        in_last   = l;
        out_ready = ordy;
        #1;
        exp_rdy = !m_alive ? 1'b0 : (m_hold ? ordy : 1'b1);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc  = v && exp_rdy;
        take = m_hold && ordy;
        m_err = 1'b0;
        if (take) m_hold = 1'b0;
        if (acc) begin
            frame_q.push_back(d);
            if (frame_q.size() == NP || l) begin
                m_out  = frame_sum();
                m_err  = (l != (frame_q.size() == NP));
                m_hold = 1'b1;
                frame_q.delete();
            end
        end
        @(posedge clk);
        m_alive = 1'b1;
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_hold));
        chk("out_data", 32'(out_data), m_out);
        chk("frame_err", 32'(frame_err), 32'(m_err));
        if (acc || take)
            $display("t=%0t in v=%0b d=%0d last=%0b acc=%0b | out take=%0b -> valid=%0b data=%0d ferr=%0b",
                     $time, v, d, l, acc, take, out_valid, out_data, frame_err);
    endtask

    // Assert reset asynchronously between edges, hold it across one edge, release.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        frame_q.delete();
        m_hold  = 1'b0;
        m_out   = 0;
        m_err   = 1'b0;
        m_alive = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("rst_in_ready_held", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        m_alive = 1'b1;
        #1;
        $display("t=%0t reset released", $time);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_hold    = 1'b0;
        m_out     = 0;
        m_err     = 1'b0;
        m_alive   = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Basic frame 1,2,3,4 with in_last on the 4th.
        for (int i = 1; i <= 4; i++) step(1'b1, i, i == 4, 1'b1);
        chk("basic_sum", 32'(out_data), 32'd10);
        chk("basic_ferr", 32'(frame_err), 32'd0);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("basic_drop", 32'(out_valid), 32'd0);

        // Largest inputs: no wrap in the accumulator.
        for (int i = 1; i <= 4; i++) step(1'b1, 131071, i == 4, 1'b1);
        chk("max_sum", 32'(out_data), 32'd524284);
        step(1'b0, 0, 1'b0, 1'b1);

        // Backpressure: held sample must stay and extra beats must be refused.
        for (int i = 1; i <= 4; i++) step(1'b1, 5, i == 4, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 99, 1'b0, 1'b0);
        chk("bp_hold_data", 32'(out_data), 32'd20);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        step(1'b1, 7, 1'b0, 1'b1);
        chk("bp_take_accept", 32'(out_valid), 32'd0);
        for (int i = 1; i <= 3; i++) step(1'b1, 1, i == 3, 1'b1);
        chk("bp_next_frame", 32'(out_data), 32'd10);

        // Streaming three frames with no bubbles.
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, i, (i % 4) == 0, 1'b1);
            if ((i % 4) == 0) chk("stream_sum", 32'(out_data), 32'(10 + 16 * (i / 4 - 1)));
        end
        step(1'b0, 0, 1'b0, 1'b1);

        // Early in_last.
        step(1'b1, 9, 1'b0, 1'b1);
        step(1'b1, 1, 1'b1, 1'b1);
        chk("early_sum", 32'(out_data), 32'd10);
        chk("early_ferr", 32'(frame_err), 32'd1);
        for (int i = 1; i <= 4; i++) step(1'b1, 1, i == 4, 1'b1);
        chk("after_early_sum", 32'(out_data), 32'd4);
        chk("after_early_ferr", 32'(frame_err), 32'd0);
        // Missing in_last.
        for (int i = 1; i <= 4; i++) step(1'b1, 2, 1'b0, 1'b1);
        chk("miss_sum", 32'(out_data), 32'd8);
        chk("miss_ferr", 32'(frame_err), 32'd1);
        step(1'b0, 0, 1'b0, 1'b1);

        // Reset mid-frame discards the partial sum.
        step(1'b1, 100, 1'b0, 1'b1);
        step(1'b1, 100, 1'b0, 1'b1);
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, i, i == 4, 1'b1);
        chk("post_reset_sum", 32'(out_data), 32'd10);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 131071),
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (3) step(1'b0, 0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_partial_accumulator.md
Name: fir_partial_accumulator

Overview:
- Consumer side of the FIR tap-pair stage: collects the stream of tap-pair partial sums, each (DATA_WIDTH+COEFF_WIDTH+1) bits wide, and reduces every NUM_PARTIALS beats into one filter output sample.
- Sits directly after the bank of tap-pair stages.
- Valid/ready on both sides, with optional in_last framing check.
- All arithmetic is unsigned, matching the upstream multiplier/adder path.

Parameters:
IN_WIDTH, 17, width of one partial sum (DATA_WIDTH+COEFF_WIDTH+1 for 8/8)
NUM_PARTIALS, 4, partial sums per output sample; legal range 2..256
ACC_WIDTH, 19, output width; must be >= IN_WIDTH+clog2(NUM_PARTIALS), checked by elaboration assertion

Ports:
clk  input  1  single clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  partial sum presented
in_ready  output  1  block accepts partial this cycle
in_data  input  IN_WIDTH  unsigned partial sum
in_last  input  1  upstream marks final partial of a sample
out_valid  output  1  accumulated sample available
out_ready  input  1  downstream accepts sample
out_data  output  ACC_WIDTH  unsigned accumulated sample
frame_err  output  1  one-cycle pulse: in_last disagreed with beat count

Behaviour:
- Reset (reset=0, async):
  - state=ACCUM, cnt=0, acc=0.
  - Outputs: out_valid=0, out_data=0, frame_err=0, in_ready=0 while reset is held.
  - in_ready=1 from the first clock after release.
- Beat acceptance: a beat is accepted when in_valid&&in_ready. A sample is taken when out_valid&&out_ready.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: acc <= (cnt==0 ? in_data : acc+in_data), zero-extended to ACC_WIDTH; cnt++.
  - Accept with cnt==NUM_PARTIALS-1, or with in_last=1: latch the final sum into out_data, go to HOLD, cnt<=0.
- State HOLD:
  - out_valid=1; out_data stable until taken.
  - in_ready=out_ready: a new beat is accepted only in a cycle where the held sample is also taken.
  - Take with no accept: go to ACCUM.
  - Take plus simultaneous accept: that beat starts the next frame (acc<=in_data, cnt<=1), state becomes ACCUM. If NUM_PARTIALS is reached or in_last is set on that beat, go straight back to HOLD with the new sum.
  - out_valid may drop only after a take. No combinational path from in_valid to out_valid.
- Latency: the final beat accepted at edge N gives out_valid=1 and the correct out_data after that edge (1 cycle). Full throughput of one beat per cycle is kept while out_ready=1.
- Framing errors:
  - in_last=1 on a beat with cnt<NUM_PARTIALS-1: frame closes early and the partial sum is emitted. frame_err pulses 1 cycle, aligned with out_valid rising.
  - in_last=0 on beat NUM_PARTIALS: frame still closes and the sum is emitted. frame_err pulses.
  - Correct framing (in_last on beat NUM_PARTIALS) gives frame_err=0.
- Width: no overflow is possible given the ACC_WIDTH constraint. There is no saturation and no truncation.
- Reset mid-frame or in HOLD: acc, cnt and any held sample are discarded. No output is produced for the aborted frame.
- in_data and in_last are ignored when in_valid=0. in_valid while in_ready=0 must not change state.
- in_ready is a function of state and out_ready only.

Test Plan:
- Basic frame: after reset, send 1,2,3,4 back-to-back with in_last on the 4th, out_ready=1 -> out_valid=1 for one cycle, one cycle after the 4th beat, out_data=10, frame_err=0.
- Overflow bound: four beats of 131071 -> out_data=524284 (0x7FFFC), with no wrap.
- Backpressure: complete frame 5,5,5,5 with out_ready=0 for 6 cycles -> out_valid stays 1, out_data stays 20, in_ready=0, extra in_valid beats are not absorbed. Raise out_ready together with in_valid and value 7 -> sample taken and 7 accepted the same cycle, cnt=1.
- Streaming: 3 frames of 4 beats with in_valid=out_ready=1 every cycle, values 1..12 -> outputs 10, 26, 42 on consecutive 4-cycle boundaries, with no bubbles.
- Early last: beats 9,1 with in_last on the 2nd -> out_data=10, frame_err pulses once; the next frame 1,1,1,1 -> 4 with frame_err=0. Missing last: 4 beats of 2 with in_last=0 -> out_data=8, frame_err pulses.
- Reset mid-frame: beats 100,100 then reset low for 1 cycle asynchronously between edges -> out_valid=0 and out_data=0 immediately. The next frame 1,2,3,4 -> 10, with no residue from 200.
